// File: rtl/qed_fifo_if.sv
// Handshake/data bundle for qed_fifo: the master drives requests, the slave (FIFO) returns data and status.
interface qed_fifo_if #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             clk_en;
    logic             flush;
    logic             wen_in;
    logic [WIDTH-1:0] data_in;
    logic             ren_in;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;

    modport master (
        output clk_en, flush, wen_in, data_in, ren_in,
        input  data_out, valid_out, empty, full, count
    );

    modport slave (
        input  clk_en, flush, wen_in, data_in, ren_in,
        output data_out, valid_out, empty, full, count
    );
endinterface

// File: rtl/qed_fifo.sv
// Synchronous FIFO with registered read data, clock enable and flush.
// Optional macro QED_FIFO_BYPASS_EN: a simultaneous write+read on an empty FIFO forwards data_in straight to data_out.
module qed_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 16
) (
    input logic      clk,
    input logic      reset,
    qed_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             valid_q, valid_d;

    logic empty, full;
    logic wr_acc, rd_acc, bypass;

    // Status depends on the registered occupancy alone, never on inputs.
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

`ifdef QED_FIFO_BYPASS_EN
    assign bypass = bus.clk_en & ~bus.flush & empty & bus.wen_in & bus.ren_in;
`else
    assign bypass = 1'b0;
`endif

    assign wr_acc = bus.clk_en & ~bus.flush & bus.wen_in & ~full & ~bypass;
    assign rd_acc = bus.clk_en & ~bus.flush & bus.ren_in & ~empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        valid_d    = valid_q;
        if (bus.clk_en) begin
            valid_d = 1'b0;
            if (bus.flush) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
            end else begin
                if (bypass) begin
                    data_out_d = bus.data_in;
                    valid_d    = 1'b1;
                end
                if (rd_acc) begin
                    data_out_d = mem[rd_ptr_q];
                    valid_d    = 1'b1;
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                end
                if (wr_acc) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
                case ({wr_acc, rd_acc})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
        end
    end

    // Storage is deliberately left unreset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= bus.data_in;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_q;
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_qed_fifo.sv
// Directed + randomized bench for qed_fifo, checked against a queue-based reference model.
module tb_qed_fifo;
    localparam int DEPTH = 32;
    localparam int WIDTH = 16;
`ifdef QED_FIFO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    qed_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();
    qed_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_dout;
    logic             m_valid;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_cycle(bit en, bit fl, bit we, bit re, logic [WIDTH-1:0] din);
        bit emp, ful;
        if (!en) return;
        if (fl) begin
            mq.delete();
            m_valid = 1'b0;
            return;
        end
        emp = (mq.size() == 0);
        ful = (mq.size() == DEPTH);
        if (BYPASS && emp && we && re) begin
            m_dout  = din;
            m_valid = 1'b1;
            return;
        end
        m_valid = 1'b0;
        if (re && !emp) begin
            m_dout  = mq.pop_front();
            m_valid = 1'b1;
        end
        if (we && !ful) mq.push_back(din);
    endtask

    task automatic check_model(string tag);
        chk({tag, "_valid"}, 32'(bus.valid_out), 32'(m_valid));
        chk({tag, "_data"},  32'(bus.data_out),  32'(m_dout));
        chk({tag, "_count"}, 32'(bus.count),     mq.size());
        chk({tag, "_empty"}, 32'(bus.empty),     32'(mq.size() == 0));
        chk({tag, "_full"},  32'(bus.full),      32'(mq.size() == DEPTH));
    endtask

    task automatic cyc(string tag, bit en, bit fl, bit we, bit re, logic [WIDTH-1:0] din);
        bus.clk_en  = en;
        bus.flush   = fl;
        bus.wen_in  = we;
        bus.ren_in  = re;
        bus.data_in = din;
        model_cycle(en, fl, we, re, din);
        @(posedge clk);
        #1;
        $display("cycle %s en=%0b fl=%0b we=%0b re=%0b din=%h -> valid=%0b dout=%h count=%0d",
                 tag, en, fl, we, re, din, bus.valid_out, bus.data_out, bus.count);
        check_model(tag);
    endtask

    task automatic drain(string tag);
        int guard = 0;
        while (mq.size() != 0 && guard < 2 * DEPTH) begin
            cyc(tag, 1, 0, 0, 1, '0);
            guard++;
        end
        chk({tag, "_drained"}, 32'(bus.count), 32'd0);
    endtask

    initial begin
        bit we, re, en, fl;
        logic [WIDTH-1:0] d;

        reset       = 1'b1;
        bus.clk_en  = 1'b0;
        bus.flush   = 1'b0;
        bus.wen_in  = 1'b0;
        bus.ren_in  = 1'b0;
        bus.data_in = '0;
        m_dout      = '0;
        m_valid     = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full",  32'(bus.full),  32'd0);
        chk("rst_valid", 32'(bus.valid_out), 32'd0);
        chk("rst_data",  32'(bus.data_out),  32'd0);
        reset = 1'b0;

        // Three writes then three reads, latency one cycle
        cyc("w1", 1, 0, 1, 0, 16'h1111);
        cyc("w2", 1, 0, 1, 0, 16'h2222);
        cyc("w3", 1, 0, 1, 0, 16'h3333);
        cyc("r1", 1, 0, 0, 1, '0);
        chk("r1_const", 32'(bus.data_out), 32'h1111);
        cyc("r2", 1, 0, 0, 1, '0);
        chk("r2_const", 32'(bus.data_out), 32'h2222);
        cyc("r3", 1, 0, 0, 1, '0);
        chk("r3_const", 32'(bus.data_out), 32'h3333);
        chk("r3_valid_const", 32'(bus.valid_out), 32'd1);
        cyc("idle", 1, 0, 0, 0, '0);
        chk("idle_valid_const", 32'(bus.valid_out), 32'd0);
        chk("idle_empty_const", 32'(bus.empty), 32'd1);

        // Fill to full, then write+read while full drops the write
        for (int i = 0; i < DEPTH; i++) cyc("fill", 1, 0, 1, 0, WIDTH'(i));
        chk("fill_full_const",  32'(bus.full),  32'd1);
        chk("fill_count_const", 32'(bus.count), 32'd32);
        cyc("full_wr", 1, 0, 1, 1, 16'hBEEF);
        chk("full_wr_data_const",  32'(bus.data_out), 32'h0000);
        chk("full_wr_count_const", 32'(bus.count),    32'd31);
        drain("drain_full");

        // Interleaved write/read pairs across pointer wrap
        for (int i = 0; i < 100; i++) begin
            d = WIDTH'($urandom);
            cyc("pair_w", 1, 0, 1, 0, d);
            chk("pair_w_le1", 32'(bus.count <= 1), 32'd1);
            cyc("pair_r", 1, 0, 0, 1, '0);
            chk("pair_r_data", 32'(bus.data_out), 32'(d));
        end

        // Flush with simultaneous write and read
        for (int i = 0; i < 5; i++) cyc("pre_flush", 1, 0, 1, 0, WIDTH'(16'h0500 + i));
        cyc("flush", 1, 1, 1, 1, 16'h7777);
        chk("flush_count_const", 32'(bus.count), 32'd0);
        chk("flush_valid_const", 32'(bus.valid_out), 32'd0);
        cyc("post_flush_rd", 1, 0, 0, 1, '0);
        chk("post_flush_valid_const", 32'(bus.valid_out), 32'd0);

        // Write+read on empty: bypass or plain write depending on build
        cyc("byp", 1, 0, 1, 1, 16'hA5A5);
        chk("byp_valid_const", 32'(bus.valid_out), 32'(BYPASS));
        chk("byp_count_const", 32'(bus.count), BYPASS ? 32'd0 : 32'd1);
        drain("drain_byp");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 9) != 0);
            fl = ($urandom_range(0, 49) == 0);
            we = ($urandom_range(0, 99) < 60);
            re = ($urandom_range(0, 99) < 45);
            cyc("rnd", en, fl, we, re, WIDTH'($urandom));
        end

        // Clock-enable hold, then asynchronous reset mid-cycle
        cyc("pre_hold_fl", 1, 1, 0, 0, '0);
        for (int i = 0; i < 5; i++) cyc("pre_hold_w", 1, 0, 1, 0, WIDTH'(16'hC000 + i));
        cyc("pre_hold_r", 1, 0, 0, 1, '0);
        for (int i = 0; i < 3; i++) cyc("hold", 0, 0, 1, 1, 16'hDEAD);
        chk("hold_count_const", 32'(bus.count), 32'd4);
        chk("hold_valid_const", 32'(bus.valid_out), 32'd1);
        chk("hold_data_const",  32'(bus.data_out), 32'hC000);
        #3;
        reset = 1'b1;
        mq.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        #1;
        $display("async reset asserted mid-cycle -> valid=%0b dout=%h count=%0d",
                 bus.valid_out, bus.data_out, bus.count);
        chk("arst_count", 32'(bus.count), 32'd0);
        chk("arst_valid", 32'(bus.valid_out), 32'd0);
        chk("arst_data",  32'(bus.data_out), 32'd0);
        chk("arst_empty", 32'(bus.empty), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc("after_rst", 1, 0, 0, 0, '0);
        cyc("after_rst_w", 1, 0, 1, 0, 16'h4242);
        cyc("after_rst_r", 1, 0, 0, 1, '0);
        cyc("after_rst_idle", 1, 0, 0, 0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/qed_fifo.md
QED_FIFO -- requirements
Module: qed_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning storage entries; power of two, at least 4.
REQ-002 SHALL have parameter WIDTH, default 16, meaning data word width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port clk_en, input, 1, global enable; when 0, no state changes except reset.
REQ-006 SHALL have port flush, input, 1, synchronous clear of contents.
REQ-007 SHALL have port wen_in, input, 1, write request.
REQ-008 SHALL have port data_in, input, WIDTH, write data.
REQ-009 SHALL have port ren_in, input, 1, read request.
REQ-010 SHALL have port data_out, output, WIDTH, registered read data.
REQ-011 SHALL have port valid_out, output, 1, data_out holds a word popped in the previous enabled cycle.
REQ-012 SHALL have port empty, output, 1, occupancy equals 0.
REQ-013 SHALL have port full, output, 1, occupancy equals DEPTH.
REQ-014 SHALL have port count, output, log2(DEPTH)+1, current occupancy.

Function
REQ-015 SHALL drive empty, full and count combinationally from the registered occupancy only, with no path from any input.
REQ-016 SHALL accept a write in an enabled cycle when wen_in=1, full=0 and flush=0; the word is stored at the write pointer and the write pointer increments modulo DEPTH.
REQ-017 SHALL accept a read in an enabled cycle when ren_in=1, empty=0 and flush=0; the word at the read pointer is registered to data_out with valid_out=1 at the next edge, and the read pointer increments modulo DEPTH.
REQ-018 SHALL have a read latency of exactly 1 enabled cycle, from accepted ren_in to valid_out=1.
REQ-019 SHALL drive valid_out=0 after any enabled cycle with no accepted read and no bypass; data_out then holds its previous value.
REQ-020 SHALL update occupancy by +1 for a write only, -1 for a read only, and leave it unchanged for a simultaneous read and write.
REQ-021 SHALL reject a write when full=1 even if a read is accepted in the same cycle, leaving the array and write pointer unchanged.
REQ-022 SHALL ignore a read when empty=1, except for the bypass of REQ-029.
REQ-023 SHALL let pointers wrap from DEPTH-1 to 0 without disturbing stored data; occupancy never exceeds DEPTH and never goes below 0.
REQ-024 SHALL, on flush=1 in an enabled cycle, zero both pointers and count and set valid_out=0 at the next edge, leave data_out unchanged, and ignore wen_in and ren_in in that cycle.
REQ-025 SHALL, when clk_en=0, hold all registers, including valid_out, at their current values.

Reset
REQ-026 SHALL, while reset=1, asynchronously force both pointers=0, count=0, data_out=0 and valid_out=0, giving empty=1 and full=0.
REQ-027 SHALL NOT require the storage array to be reset; contents are unobservable until written.
REQ-028 SHALL, on reset asserted mid-operation, discard all in-flight reads and writes, with no valid_out pulse after release until a new accepted read.

Configuration
REQ-029 SHALL, with macro QED_FIFO_BYPASS_EN defined, treat an enabled cycle with empty=1, wen_in=1, ren_in=1 and flush=0 as follows: data_in goes to data_out with valid_out=1 at the next edge, the word is not stored, and pointers and count are unchanged.
REQ-030 SHALL, without QED_FIFO_BYPASS_EN, in that same cycle accept the write only (count becomes 1) and give valid_out=0 at the next edge.

Verification
REQ-031 SHALL pass: reset, write 0x1111, 0x2222, 0x3333, then read three times; valid_out is 1 on the 3 cycles after the reads, data_out is 0x1111, 0x2222, 0x3333, and count returns to 0 with empty=1.
REQ-032 SHALL pass: write 32 words 0x0000..0x001F; full=1 and count=32; a further write of 0xBEEF with ren_in=1 pops 0x0000, drops 0xBEEF, and gives count=31.
REQ-033 SHALL pass: 100 interleaved write/read pairs across pointer wrap; output sequence equals input sequence and count stays at 1 or less.
REQ-034 SHALL pass: with 5 words stored, assert flush together with wen_in and ren_in; next cycle count=0, empty=1, valid_out=0, and a following read is ignored.
REQ-035 SHALL pass: on an empty FIFO, apply wen_in=ren_in=1 with data 0xA5A5; with QED_FIFO_BYPASS_EN, next cycle data_out=0xA5A5, valid_out=1, count=0; without it, valid_out=0 and count=1.
REQ-036 SHALL pass: hold clk_en=0 for 3 cycles with wen_in and ren_in active, then assert reset mid-cycle with 4 words stored; nothing changes while disabled, and on reset count=0, valid_out=0 and data_out=0 immediately without waiting for a clock edge.
